// File: rtl/switch_hex_counter_pkg.sv
// switch_hex_counter_pkg: shared widths and default debounce length for the switch counter
package switch_hex_counter_pkg;
    localparam int DEBOUNCE_LIMIT_DEFAULT = 250000;
    localparam int COUNT_W = 8;
    localparam int NIBBLE_W = 4;
endpackage

// File: rtl/switch_hex_counter_debounce_filter.sv
// debounce_filter: two-flop synchronizer followed by a consecutive-mismatch debounce counter
module debounce_filter
    import switch_hex_counter_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Bouncy,
    output logic o_Debounced
);
    localparam int CW = $clog2(DEBOUNCE_LIMIT) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          match, done;

    // Accept a new level only after LIMIT consecutive mismatching cycles; any match restarts
    always_comb begin
        sync1_d  = i_Bouncy;
        sync2_d  = sync1_q;
        match    = sync2_q == stable_q;
        done     = !match && cnt_q == LAST;
        cnt_d    = (match || done) ? '0 : cnt_q + 1'b1;
        stable_d = done ? sync2_q : stable_q;
    end

    // State registers, cleared by reset so a partial debounce is discarded
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_Debounced = stable_q;
endmodule

// File: rtl/switch_hex_counter.sv
// switch_hex_counter: counts debounced switch releases into an 8-bit value split into two nibbles
module switch_hex_counter
    import switch_hex_counter_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Switch_Inc,
    input  logic                i_Switch_Clr,
    output logic [NIBBLE_W-1:0] o_Count_Hi,
    output logic [NIBBLE_W-1:0] o_Count_Lo,
    output logic                o_Update
);
    logic               inc_db, clr_db;
    logic               prev_inc_q, prev_inc_d;
    logic               prev_clr_q, prev_clr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               update_q, update_d;
    logic               inc_ev, clr_ev;

    debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_inc (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Bouncy   (i_Switch_Inc),
        .o_Debounced(inc_db)
    );

    debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_clr (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Bouncy   (i_Switch_Clr),
        .o_Debounced(clr_db)
    );

    // Releases are the events; clear takes priority over a simultaneous increment
    always_comb begin
        inc_ev     = prev_inc_q & ~inc_db;
        clr_ev     = prev_clr_q & ~clr_db;
        prev_inc_d = inc_db;
        prev_clr_d = clr_db;
        count_d    = clr_ev ? '0 : inc_ev ? count_q + 1'b1 : count_q;
        update_d   = inc_ev | clr_ev;
    end

    // Edge history, count and update pulse registers
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            prev_inc_q <= 1'b0;
            prev_clr_q <= 1'b0;
            count_q    <= '0;
            update_q   <= 1'b0;
        end else begin
            prev_inc_q <= prev_inc_d;
            prev_clr_q <= prev_clr_d;
            count_q    <= count_d;
            update_q   <= update_d;
        end
    end

    assign o_Count_Hi = count_q[COUNT_W-1 -: NIBBLE_W];
    assign o_Count_Lo = count_q[NIBBLE_W-1:0];
    assign o_Update   = update_q;
endmodule

// File: doc/switch_hex_counter.md
# switch_hex_counter

Counts debounced push-button releases into an 8-bit value and presents it as two 4-bit nibbles for the pair of `binary_to_7segment` decoders that drive the dual 7-segment display. It sits directly upstream of those decoders: raw board switches in, stable nibbles out. One switch increments the count and a second switch clears it. Each switch gets its own synchronizer and debounce filter.

## Interface
- `DEBOUNCE_LIMIT`, default 250000: number of consecutive cycles a synchronized input must differ from its stable state before that state is accepted (10 ms at 25 MHz). Must be ≥ 1.
- `i_Clk` input 1: system clock, 25 MHz on the board.
- `i_Rst` input 1: reset, synchronous, active-high.
- `i_Switch_Inc` input 1: raw increment switch, asynchronous, 1 = pressed.
- `i_Switch_Clr` input 1: raw clear switch, asynchronous, 1 = pressed.
- `o_Count_Hi` output 4: count[7:4], for the tens-digit decoder.
- `o_Count_Lo` output 4: count[3:0], for the ones-digit decoder.
- `o_Update` output 1: one-cycle pulse on the cycle the count register is written.

## Operation
- Per switch, the chain is:
  - two-flop synchronizer (sync1, sync2);
  - debounce filter: counter `cnt` (width `$clog2(DEBOUNCE_LIMIT)+1`) and stable state `stable`;
  - edge register `prev` <= `stable`.
- Debounce rule, evaluated each edge on pre-edge values:
  - `sync2 == stable` → `cnt` <= 0.
  - `sync2 != stable` and `cnt == DEBOUNCE_LIMIT-1` → `stable` <= `sync2`, `cnt` <= 0.
  - Otherwise → `cnt` <= `cnt` + 1.
- A mismatch shorter than `DEBOUNCE_LIMIT` consecutive cycles never changes `stable`. Any match restarts the count.
- Event = release = `prev & ~stable` (debounced 1→0). A press alone generates no event.
- Count update, registered:
  - clr event → count <= 8'h00.
  - else inc event → count <= count + 1, wrapping 8'hFF → 8'h00.
  - Simultaneous clr and inc events: clear wins, and the increment is discarded.
- `o_Update` <= 1 on any edge where an inc or clr event is present, including a clear while already at 00 or a wrap. It is 0 otherwise.
- Reset: sync flops, `cnt`, `stable`, `prev`, count and `o_Update` all go to 0.
  - After reset: `o_Count_Hi` = 0, `o_Count_Lo` = 0, `o_Update` = 0.
- Reset mid-debounce discards the partial count.
- A switch held through reset debounces to `stable` = 1 afterwards with no event. Its later release counts normally.

## Timing
- Let the switch take its new level before edge E1, the first edge that samples it, and hold it.
- Pipeline:
  - edge E2: sync2 takes the new level;
  - edge E(DEBOUNCE_LIMIT+2): `stable` flips;
  - edge E(DEBOUNCE_LIMIT+3): count and `o_Update` change.
- Latency from E1 to the count change is `DEBOUNCE_LIMIT+2` cycles.
- Events from one switch are at least `2*DEBOUNCE_LIMIT` cycles apart (press + release), so no event is ever lost.
- Outputs are registered with no combinational path from input to output.
- The downstream decoder adds its own one cycle.

## Structure
- Shared package/header:
  - `DEBOUNCE_LIMIT` default value;
  - count width (8);
  - nibble width (4).
- Sub-module `debounce_filter`:
  - contains the synchronizer, debounce counter and `stable` register;
  - parameter `DEBOUNCE_LIMIT`;
  - ports `i_Clk`, `i_Rst`, `i_Bouncy`, `o_Debounced`;
  - instantiated twice.
- Top level holds the `prev` registers, the event logic, the count register and `o_Update`.

## Test plan
All scenarios use `DEBOUNCE_LIMIT` = 4.
- Reset, then idle 20 cycles → `o_Count_Hi`/`o_Count_Lo` = 0/0, `o_Update` never asserted.
- Inc press held 10 cycles, then released 10 cycles → exactly one `o_Update` pulse, count 0/1, pulse on the 7th edge after the release level is first sampled.
- Inc press with 3-cycle bounces (1,0,1,0) before settling, then the same on release → only one increment counted.
- 255 clean inc press/release pairs, then one more → count F/F, then 0/0 with an `o_Update` pulse at the wrap.
- Count at 0/5, inc and clr released on the same cycle → count 0/0, single `o_Update` pulse.
- Inc held and `i_Rst` asserted for 1 cycle mid-debounce, then switch released → no count from the held press, one increment on release (0/1).
